// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared divider handshake constants, FSM states and helpers
package div_unit_pkg;
  localparam int WIDTH = 32;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage divide request/response handshake
interface div_unit_if;
  import div_unit_pkg::*;
  logic signed_div_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic start_i;
  logic annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic ready_o;
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit_step.sv
// div_unit_step: one combinational restoring-division step
module div_unit_step
  import div_unit_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q
);
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  assign sh = {rem, din};
  assign diff = sh - {1'b0, divisor};
  assign q = sh >= {1'b0, divisor};
  assign rem_nx = q ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: 32-step restoring divider answering the EX-stage divide handshake
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   div
);
  div_state_e state;
  logic [5:0] cnt;
  logic [WIDTH-1:0] dividend, divisor, quo, rem, rem_nx;
  logic s1, s2, qbit;
  div_unit_step u_step (
    .rem(rem),
    .din(dividend[WIDTH-1]),
    .divisor(divisor),
    .rem_nx(rem_nx),
    .q(qbit)
  );
  // s1/s2 are already masked by signed_div, so the fix-up needs no mode check
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= DivFree;
      cnt <= '0;
      dividend <= '0;
      divisor <= '0;
      quo <= '0;
      rem <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      div.result_o <= '0;
      div.ready_o <= DivResultNotReady;
    end else
      case (state)
        DivFree: begin
          div.ready_o <= DivResultNotReady;
          div.result_o <= '0;
          if (div.start_i == DivStart && !div.annul_i) begin
            if (div.opdata2_i == '0) state <= DivByZero;
            else begin
              state <= DivOn;
              dividend <= mag(div.opdata1_i, div.signed_div_i);
              divisor <= mag(div.opdata2_i, div.signed_div_i);
              s1 <= div.signed_div_i & div.opdata1_i[WIDTH-1];
              s2 <= div.signed_div_i & div.opdata2_i[WIDTH-1];
              cnt <= '0;
              rem <= '0;
              quo <= '0;
            end
          end
        end
        DivByZero: begin
          state <= DivEnd;
          div.result_o <= '0;
          div.ready_o <= DivResultReady;
        end
        DivOn:
          if (div.annul_i) state <= DivFree;
          else if (cnt != 6'd32) begin
            rem <= rem_nx;
            quo <= {quo[WIDTH-2:0], qbit};
            dividend <= {dividend[WIDTH-2:0], 1'b0};
            cnt <= cnt + 6'd1;
          end else begin
            div.result_o <= {s1 ? -rem : rem, (s1 ^ s2) ? -quo : quo};
            div.ready_o <= DivResultReady;
            state <= DivEnd;
          end
        DivEnd:
          if (div.annul_i || div.start_i == DivStop) begin
            state <= DivFree;
            div.ready_o <= DivResultNotReady;
            div.result_o <= '0;
          end
      endcase
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors, scoreboard queue checked by an independent monitor
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  div_unit_if bus();
  div_unit dut (.clk(clk), .rst(rst), .div(bus));
  logic [63:0] exp_q[$];
  int cyc_q[$];
  string name_q[$];
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic prev_rdy = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  always @(negedge clk) begin
    if (bus.ready_o && !prev_rdy) begin
      if (exp_q.size() == 0) check("unexpected_ready", {63'd0, bus.ready_o}, 64'd0);
      else begin
        string n;
        n = name_q.pop_front();
        check({n, "_result"}, bus.result_o, exp_q.pop_front());
        check({n, "_latency"}, 64'(cyc), 64'(cyc_q.pop_front()));
      end
    end
    prev_rdy = bus.ready_o;
  end
  task automatic start_div(input string n, input logic sd, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat, input bit push);
    @(negedge clk);
    bus.signed_div_i = sd;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + 1 + lat);
      name_q.push_back(n);
    end
  endtask
  task automatic wait_ready(input string n);
    int i = 0;
    while (!bus.ready_o && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (!bus.ready_o) check({n, "_timeout"}, {63'd0, bus.ready_o}, 64'd1);
  endtask
  task automatic finish_div(input string n, input logic [63:0] exp, input int hold);
    wait_ready(n);
    repeat (hold) begin
      @(negedge clk);
      check({n, "_hold_res"}, bus.result_o, exp);
      check({n, "_hold_rdy"}, {63'd0, bus.ready_o}, 64'd1);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    check({n, "_drop_rdy"}, {63'd0, bus.ready_o}, 64'd0);
    check({n, "_drop_res"}, bus.result_o, 64'd0);
  endtask
  task automatic div_case(input string n, input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input int hold);
    start_div(n, sd, a, b, exp, lat, 1'b1);
    finish_div(n, exp, hold);
  endtask
  initial begin
    int seen;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    #1;
    check("reset_rdy", {63'd0, bus.ready_o}, 64'd0);
    check("reset_res", bus.result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    div_case("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1);
    div_case("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    div_case("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
    div_case("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 33, 0);
    div_case("s_m8_m3", 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 33, 0);
    div_case("u5_7", 1'b0, 32'd5, 32'd7, 64'h00000005_00000000, 33, 0);
    div_case("divzero", 1'b0, 32'd1234, 32'd0, 64'd0, 1, 5);
    // annul mid-division: ready must never rise, and no scoreboard entry exists
    start_div("annul", 1'b0, 32'd1000, 32'd3, 64'd0, 33, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) seen++;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    div_case("u_ffff_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 0);
    start_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd4;
    bus.signed_div_i = 1'b0;
    finish_div("s_min_m1", 64'h00000000_80000000, 0);
    // async reset mid-division
    start_div("rst_on", 1'b0, 32'd250, 32'd5, 64'd0, 33, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_on_rdy", {63'd0, bus.ready_o}, 64'd0);
    check("rst_on_res", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // async reset while holding a finished result must clear it without a clock edge
    start_div("rst_end", 1'b0, 32'd250, 32'd5, 64'h00000000_00000032, 33, 1'b1);
    wait_ready("rst_end");
    #2 rst = 1'b0;
    #1;
    check("rst_end_rdy", {63'd0, bus.ready_o}, 64'd0);
    check("rst_end_res", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    div_case("after_rst", 1'b1, 32'hFFFFFFF8, 32'd3, 64'hFFFFFFFE_FFFFFFFE, 33, 0);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider. It is the responder side of the EX-stage divide handshake.
- EX raises start with the operands and holds them. This block runs a 32-step restoring division, then raises ready with {remainder, quotient}.
- EX writes the result to HI/LO and stalls the pipeline while ready is low. Instantiated beside EX in the CPU top level.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported. result_o is 2*WIDTH bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- signed_div_i  in  1  1 = signed division, 0 = unsigned.
- opdata1_i  in  32  dividend; held stable by EX while start_i is high.
- opdata2_i  in  32  divisor; held stable by EX while start_i is high.
- start_i  in  1  DivStart request, level-sensitive.
- annul_i  in  1  cancel the in-flight division (pipeline flush).
- result_o  out  64  [63:32] remainder (to HI), [31:0] quotient (to LO). Registered.
- ready_o  out  1  DivResultReady. Registered.

Behaviour:
- Reset (rst=0, async): state=FREE, cnt=0, result_o=0, ready_o=0, internal remainder/quotient/divisor registers = 0. Reset during any state aborts with no output.
- FSM states: FREE, BYZERO, ON, END.
- FREE, start_i=1 and annul_i=0:
  - opdata2_i==0 -> BYZERO.
  - Otherwise -> ON. Latch |opdata1| and |opdata2| (two's-complement magnitude when signed_div_i=1 and the operand MSB=1, raw value otherwise). Latch both sign bits. cnt=0, partial remainder=0.
- FREE, otherwise: stay. ready_o=0, result_o=0.
- BYZERO: next edge -> END with result_o=0.
- ON, annul_i=1: -> FREE. ready_o stays 0; result is discarded.
- ON, cnt<32: one restoring step per cycle, then cnt++.
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - If shifted value >= divisor: subtract the divisor and shift 1 into the quotient; else shift in 0.
  - Compare and subtract are 33 bits wide.
- ON, cnt==32: sign fix-up, then -> END.
  - Quotient is negated when signed and the operand signs differ.
  - Remainder is negated when signed and the dividend was negative (remainder takes the dividend's sign).
  - result_o={rem,quo}, ready_o=1.
- END: hold ready_o=1 and result_o stable while start_i=1. When start_i=0: -> FREE, with ready_o=0 and result_o=0 on that edge.
- END, annul_i=1: -> FREE.
- Latency, nonzero divisor: start sampled at edge E0; ready_o=1 after edge E33.
- Latency, divide-by-zero: ready_o=1 after edge E1.
- Boundary: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps), remainder 0. No trap.
- Boundary: start_i high in ON or BYZERO is ignored. Operand changes after E0 are ignored (operands are latched).
- No combinational path from inputs to outputs.

Decomposition:
- State encodings DivFree/DivByZero/DivOn/DivEnd (2-bit) go in defines.v. So do DivStart/DivStop and DivResultReady/DivResultNotReady, shared with EX.
- Optional sub-module div_step: combinational single restoring step.
  - In: 32-bit remainder, incoming dividend bit, 32-bit divisor.
  - Out: next remainder, quotient bit.

Test Plan:
- Unsigned 100/7: start at E0 -> ready_o=1 after E33, result_o=0x00000002_0000000E. Drop start -> ready_o=0, result_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9 / 0x2) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD. Unsigned 0xFFFFFFF9/2 -> 0x00000001_7FFFFFFC.
- Divide-by-zero 1234/0 -> ready_o=1 after E1, result_o=0. Hold start 5 cycles -> output stable.
- Annul at cycle 10 of ON -> FREE, ready_o never rises. Then unsigned 0xFFFFFFFF/1 -> result_o=0x00000000_FFFFFFFF after 33 edges.
- Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000. Change operands at E5 -> result unaffected.
- Assert rst=0 asynchronously mid-ON (no clock edge) -> ready_o=0, result_o=0 immediately. After release, a new start completes normally.
